// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles (optional ID_EX_STALL_CNT_EN bubble counter)
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       bubble_count,
`endif
    output logic              ex_mem_read
);

    logic              r_valid;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic              r_alu_src;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_reg_write;
    logic              r_mem_read;

    logic              w_luse;
    logic              w_load_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] reg_val,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_val,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_val
    );
        logic [DATA_W-1:0] v;
        v = reg_val;
        if (em_we && (em_rd != '0) && (em_rd == addr)) begin
            v = em_val;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == addr)) begin
            v = mw_val;
        end
        return v;
    endfunction

    // A load in EX whose destination is read by the instruction in decode cannot be forwarded in time.
    assign w_luse = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                    ((r_rd == id_rs_addr) || ((r_rd == id_rt_addr) && !id_alu_src));

    assign stall = w_luse || ex_hold;

    // Flush always kills the incoming slot; a load-use bubble only lands when EX is free to advance.
    assign w_load_bubble = flush || (!ex_hold && w_luse);

    // Pipeline register: reset and bubbles clear every field, hold retains, otherwise capture decode.
    always_ff @(posedge clk) begin
        if (!rst_n || w_load_bubble) begin
            r_valid     <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (!ex_hold) begin
            r_valid     <= id_valid;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_rd        <= id_rd_addr;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_alu_op    <= id_alu_op;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
        end
    end

    // Operand forwarding from the registered source addresses.
    always_comb begin
        w_fwd_rs = fwd_sel(r_rs_addr, r_rs_data, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
        w_fwd_rt = fwd_sel(r_rt_addr, r_rt_data, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_result);
    end

    assign ex_valid      = r_valid;
    assign ex_a          = w_fwd_rs;
    assign ex_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_alu_op     = r_alu_op;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_valid && r_reg_write;
    assign ex_mem_read   = r_valid && r_mem_read;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] r_bubble_count;

    // Saturating count of bubbles caused by flush or load-use while EX is advancing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (!ex_hold && (flush || w_luse) && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [5:0]  id_alu_op;
    logic        id_reg_write, id_mem_read;
    logic        flush, ex_hold;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [5:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] bubble_count;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ex_hold(ex_hold),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write),
`ifdef ID_EX_STALL_CNT_EN
        .bubble_count(bubble_count),
`endif
        .ex_mem_read(ex_mem_read)
    );

    // Contents of the EX slot as the reference model sees it.
    typedef struct packed {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic        src;
        logic [5:0]  op;
        logic        rw, mr;
    } slot_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [31:0] rsd;
        logic        emw;
        logic [4:0]  emrd;
        logic [31:0] emres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
        logic [31:0] exp_a;
    } fwd_vec_t;

    slot_t m;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 0) return v;
        if (exmem_reg_write && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd == a) return memwb_result;
        return v;
    endfunction

    function automatic logic model_luse();
        if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (m.rd == id_rs_addr) || (m.rd == id_rt_addr && !id_alu_src);
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] rt_f;
        rt_f = model_fwd(m.rt, m.rtd);
        chk({tag, ".stall"}, 32'(stall), 32'(model_luse() || ex_hold));
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.v));
        chk({tag, ".ex_a"}, ex_a, model_fwd(m.rs, m.rsd));
        chk({tag, ".ex_b"}, ex_b, m.src ? m.imm : rt_f);
        chk({tag, ".ex_store_data"}, ex_store_data, rt_f);
        chk({tag, ".ex_alu_op"}, 32'(ex_alu_op), 32'(m.op));
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
        chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m.v && m.rw));
        chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m.v && m.mr));
    endtask

    // Advance one clock, moving the model's EX slot alongside the DUT.
    task automatic tick();
        slot_t nxt;
        nxt = m;
        if (!rst_n || flush) nxt = '0;
        else if (ex_hold) nxt = m;
        else if (model_luse()) nxt = '0;
        else nxt = '{v: id_valid, rs: id_rs_addr, rt: id_rt_addr, rd: id_rd_addr,
                     rsd: id_rs_data, rtd: id_rt_data, imm: id_imm, src: id_alu_src,
                     op: id_alu_op, rw: id_reg_write, mr: id_mem_read};
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic clear_in();
        rst_n = 1'b1; id_valid = 1'b0;
        id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_alu_src = 1'b0; id_alu_op = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        flush = 1'b0; ex_hold = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    fwd_vec_t fv [6];

    initial begin
        fv[0] = '{rs: 5'd3, rsd: 32'd11, emw: 1'b1, emrd: 5'd3, emres: 32'hAAAA0000, mww: 1'b1, mwrd: 5'd3, mwres: 32'h5555, exp_a: 32'hAAAA0000};
        fv[1] = '{rs: 5'd3, rsd: 32'd11, emw: 1'b0, emrd: 5'd3, emres: 32'hAAAA0000, mww: 1'b1, mwrd: 5'd3, mwres: 32'h5555, exp_a: 32'h5555};
        fv[2] = '{rs: 5'd0, rsd: 32'h1234, emw: 1'b1, emrd: 5'd0, emres: 32'hAAAA0000, mww: 1'b1, mwrd: 5'd0, mwres: 32'h5555, exp_a: 32'h1234};
        fv[3] = '{rs: 5'd7, rsd: 32'd77, emw: 1'b1, emrd: 5'd6, emres: 32'h1111, mww: 1'b1, mwrd: 5'd7, mwres: 32'hBEEF, exp_a: 32'hBEEF};
        fv[4] = '{rs: 5'd7, rsd: 32'd77, emw: 1'b1, emrd: 5'd6, emres: 32'h1111, mww: 1'b0, mwrd: 5'd7, mwres: 32'hBEEF, exp_a: 32'd77};
        fv[5] = '{rs: 5'd5, rsd: 32'd55, emw: 1'b1, emrd: 5'd5, emres: 32'hC0DE, mww: 1'b1, mwrd: 5'd0, mwres: 32'hBEEF, exp_a: 32'hC0DE};

        m = '0;
        clear_in();

        // Reset with a valid instruction presented.
        rst_n = 1'b0; id_valid = 1'b1; id_alu_op = 6'h21; id_reg_write = 1'b1; id_rd_addr = 5'd9;
        tick();
        tick();
        chk("rst.ex_valid", 32'(ex_valid), 32'd0);
        chk("rst.ex_alu_op", 32'(ex_alu_op), 32'd0);
        chk("rst.ex_reg_write", 32'(ex_reg_write), 32'd0);
        check_all("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_rel.ex_alu_op", 32'(ex_alu_op), 32'h21);
        chk("rst_rel.ex_valid", 32'(ex_valid), 32'd1);

        // Forwarding table.
        for (int i = 0; i < 6; i++) begin
            clear_in();
            id_valid = 1'b1; id_rs_addr = fv[i].rs; id_rs_data = fv[i].rsd; id_alu_op = 6'h02;
            tick();
            exmem_reg_write = fv[i].emw; exmem_rd = fv[i].emrd; exmem_result = fv[i].emres;
            memwb_reg_write = fv[i].mww; memwb_rd = fv[i].mwrd; memwb_result = fv[i].mwres;
            #1;
            chk($sformatf("fwd%0d.ex_a", i), ex_a, fv[i].exp_a);
            check_all($sformatf("fwd%0d", i));
        end

        // Immediate select with forwarded store data.
        clear_in();
        id_valid = 1'b1; id_rt_addr = 5'd4; id_rt_data = 32'd1; id_alu_src = 1'b1; id_imm = 32'hFFFFFFF0;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h7;
        #1;
        chk("imm.ex_b", ex_b, 32'hFFFFFFF0);
        chk("imm.ex_store_data", ex_store_data, 32'h7);

        // Load-use: one bubble, then the consumer picks the load value from MEM/WB.
        clear_in();
        id_valid = 1'b1; id_rd_addr = 5'd8; id_mem_read = 1'b1; id_reg_write = 1'b1;
        tick();
        clear_in();
        id_valid = 1'b1; id_rs_addr = 5'd8; id_rd_addr = 5'd10; id_reg_write = 1'b1; id_rs_data = 32'h0BAD;
        #1;
        chk("luse.stall", 32'(stall), 32'd1);
        tick();
        chk("luse.bubble_valid", 32'(ex_valid), 32'd0);
        chk("luse.stall_clear", 32'(stall), 32'd0);
        check_all("luse_bubble");
        tick();
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'hDEADBEEF;
        #1;
        chk("luse.consumer_valid", 32'(ex_valid), 32'd1);
        chk("luse.ex_a", ex_a, 32'hDEADBEEF);
        check_all("luse_consumer");

        // Flush beats hold; then hold alone freezes EX for three cycles.
        clear_in();
        id_valid = 1'b1; id_alu_op = 6'h11; id_reg_write = 1'b1; id_rd_addr = 5'd2;
        tick();
        flush = 1'b1; ex_hold = 1'b1;
        tick();
        chk("flush_hold.ex_valid", 32'(ex_valid), 32'd0);
        check_all("flush_hold");
        clear_in();
        id_valid = 1'b1; id_alu_op = 6'h2A; id_rd_addr = 5'd6; id_rs_addr = 5'd1; id_rs_data = 32'h600D;
        tick();
        ex_hold = 1'b1; id_alu_op = 6'h3F; id_rd_addr = 5'd31; id_rs_data = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk($sformatf("hold%0d.ex_alu_op", c), 32'(ex_alu_op), 32'h2A);
            chk($sformatf("hold%0d.ex_rd", c), 32'(ex_rd), 32'd6);
            chk($sformatf("hold%0d.ex_a", c), ex_a, 32'h600D);
            chk($sformatf("hold%0d.stall", c), 32'(stall), 32'd1);
            check_all($sformatf("hold%0d", c));
        end

`ifdef ID_EX_STALL_CNT_EN
        // Bubble counter: two load-use bubbles plus one flush, then saturation.
        do_reset();
        chk("cnt.reset", bubble_count, 32'd0);
        for (int k = 0; k < 2; k++) begin
            clear_in();
            id_valid = 1'b1; id_rd_addr = 5'd8; id_mem_read = 1'b1;
            tick();
            clear_in();
            id_valid = 1'b1; id_rs_addr = 5'd8;
            tick();
        end
        clear_in();
        flush = 1'b1;
        tick();
        chk("cnt.three", bubble_count, 32'd3);
        dut.r_bubble_count = 32'hFFFF_FFFF;
        tick();
        chk("cnt.saturate", bubble_count, 32'hFFFF_FFFF);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int r = 0; r < 400; r++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs_addr = 5'($urandom_range(0, 3));
            id_rt_addr = 5'($urandom_range(0, 3));
            id_rd_addr = 5'($urandom_range(0, 3));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_alu_src = 1'($urandom_range(0, 1));
            id_alu_op = 6'($urandom_range(0, 63));
            id_reg_write = 1'($urandom_range(0, 1));
            id_mem_read = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 5) == 0);
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd = 5'($urandom_range(0, 3));
            memwb_result = $urandom;
            #1;
            check_all($sformatf("rnd%0d", r));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
